// File: rtl/uart_pkg.sv
// Shared UART front-end types: receiver FSM states, default frame constants, parity helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP  = 3'd4
   } rx_state_e;

   // Callers zero-extend narrower words; XOR of the padding is 0.
   function automatic logic even_parity(input logic [31:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Baud divider: pulses tick for one clock every BAUD_DIV enabled clocks; clr holds it at zero.
module uart_tick_gen #(
   parameter int BAUD_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && (cnt_q == CW'(BAUD_DIV - 1));
      cnt_d = cnt_q;
      if (clr || tick)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output and frame/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = 4,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   input  logic                 ready,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int OW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [1:0]           sync_q, sync_d;
   rx_state_e            state_q, state_d;
   logic [OW-1:0]        os_cnt_q, os_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q, par_bit_d;
   logic                 perr_q, perr_d;
`endif

   logic rxs, tick, half, full, done;

   assign rxs = sync_q[1];

   uart_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != ST_IDLE),
      .clr  (state_q == ST_IDLE),
      .tick (tick)
   );

   always_comb begin
      sync_d    = {sync_q[0], rxd};
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = ferr_q;
      ovr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d = par_bit_q;
      perr_d    = perr_q;
`endif
      done = 1'b0;
      half = tick && (os_cnt_q == OW'(OVERSAMPLE/2 - 1));
      full = tick && (os_cnt_q == OW'(OVERSAMPLE - 1));

      case (state_q)
         ST_IDLE:  if (!rxs) state_d = ST_START;
         ST_START: if (half) begin
            state_d   = rxs ? ST_IDLE : ST_DATA;
            bit_cnt_d = '0;
         end
         ST_DATA:  if (full) begin
            shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: if (full) begin
            par_bit_d = rxs;
            state_d   = ST_STOP;
         end
`endif
         ST_STOP:  if (full) begin
            state_d = ST_IDLE;
            done    = 1'b1;
         end
         default:  state_d = ST_IDLE;
      endcase

      // Counter restarts on every state change so each phase measures from its own entry.
      os_cnt_d = os_cnt_q;
      if (state_d != state_q || state_q == ST_IDLE)
         os_cnt_d = '0;
      else if (tick)
         os_cnt_d = full ? '0 : os_cnt_q + OW'(1);

      if (valid_q && ready)
         valid_d = 1'b0;
      if (done) begin
         if (!valid_q || ready) begin
            data_d  = shift_q;
            ferr_d  = ~rxs;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = even_parity(32'(shift_q)) ^ par_bit_q;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q    <= 2'b11;
         state_q   <= ST_IDLE;
         os_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         os_cnt_q  <= os_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= par_bit_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (64 clocks per bit).
module tb_uart_rx;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data_out;
   logic       valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int total = 0;
   int bad   = 0;

   // Monitor-owned bookkeeping: cycles with valid high, overrun pulses, last presented byte.
   int         vcnt = 0;
   int         ocnt = 0;
   logic [7:0] last_d = '0;
   logic       last_fe = 1'b0;
   logic       last_pe = 1'b0;

   uart_rx dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .ready     (ready),
      .data_out  (data_out),
      .valid     (valid),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         vcnt++;
         last_d  = data_out;
         last_fe = frame_err;
`ifdef UART_RX_PARITY_EN
         last_pe = parity_err;
`endif
      end
      if (overrun) ocnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      clocks(64);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par_b);
`else
      if (par_b) rxd = 1'b1;
`endif
      send_bit(stop_b);
      rxd = 1'b1;
   endtask

   int v0, o0;

   initial begin
      // reset values
      clocks(5);
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      rst = 1'b1;
      clocks(10);

      // 1: 0xA5 8N1, ready high -> one-cycle valid
      v0 = vcnt;
      send_frame(8'hA5, 1'b1, ^8'hA5);
      clocks(10);
      check("t1_vcycles", 32'(vcnt - v0), 32'd1);
      check("t1_data", 32'(last_d), 32'hA5);
      check("t1_ferr", 32'(last_fe), 32'h0);
      check("t1_hold", 32'(data_out), 32'hA5);

      // 2: 20-clock glitch is rejected at the start sample
      v0 = vcnt;
      rxd = 1'b0;
      clocks(10);
      check("t2_in_start", 32'(dut.state_q), 32'(ST_START));
      clocks(10);
      rxd = 1'b1;
      clocks(20);
      check("t2_idle_by40", 32'(dut.state_q), 32'(ST_IDLE));
      clocks(100);
      check("t2_no_valid", 32'(vcnt - v0), 32'd0);

      // 3: 0x3C with bad stop bit, held until consumed
      ready = 1'b0;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      clocks(100);
      check("t3_valid", 32'(valid), 32'h1);
      check("t3_data", 32'(data_out), 32'h3C);
      check("t3_ferr", 32'(frame_err), 32'h1);
      ready = 1'b1;
      clocks(1);
      ready = 1'b0;
      check("t3_consumed", 32'(valid), 32'h0);

      // 4: back-to-back 0x11, 0x22 with ready low -> single overrun, first byte kept
      o0 = ocnt;
      send_frame(8'h11, 1'b1, ^8'h11);
      check("t4_no_ovr_yet", 32'(ocnt - o0), 32'd0);
      send_frame(8'h22, 1'b1, ^8'h22);
      clocks(10);
      check("t4_ovr_once", 32'(ocnt - o0), 32'd1);
      check("t4_data_kept", 32'(data_out), 32'h11);
      check("t4_valid", 32'(valid), 32'h1);
      ready = 1'b1;
      clocks(1);
      check("t4_drop", 32'(valid), 32'h0);

      // 5: reset mid-frame after 4 data bits of 0xFF, then a clean 0x5A
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst = 1'b0;
      rxd = 1'b1;
      clocks(3);
      check("t5_rst_data", 32'(data_out), 32'h0);
      check("t5_rst_valid", 32'(valid), 32'h0);
      check("t5_rst_ferr", 32'(frame_err), 32'h0);
      check("t5_rst_ovr", 32'(overrun), 32'h0);
      check("t5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b1;
      clocks(100);
      v0 = vcnt;
      send_frame(8'h5A, 1'b1, ^8'h5A);
      clocks(10);
      check("t5_vcycles", 32'(vcnt - v0), 32'd1);
      check("t5_data", 32'(last_d), 32'h5A);
      check("t5_ferr", 32'(last_fe), 32'h0);

`ifdef UART_RX_PARITY_EN
      // 6: 0x07 has odd weight; parity bit 0 is wrong, 1 is right
      v0 = vcnt;
      send_frame(8'h07, 1'b1, 1'b0);
      clocks(10);
      check("t6_vcycles_a", 32'(vcnt - v0), 32'd1);
      check("t6_perr_set", 32'(last_pe), 32'h1);
      send_frame(8'h07, 1'b1, 1'b1);
      clocks(10);
      check("t6_perr_clr", 32'(last_pe), 32'h0);
      check("t6_data", 32'(last_d), 32'h07);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that turns the serial `rxd` line into parallel bytes with a valid/ready handshake. It sits directly upstream of the FIR filter's sample input, beside the transmitter, in the UART front end. Bit timing is tracked with the team's enable-driven counter style: a baud-tick divider plus a per-bit oversample counter.

## Interface
- `BAUD_DIV`, 4: clocks per oversample tick. Must be ≥ 1.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Synchronous, active-low; clock `clk`.
- `rxd`, input, 1: asynchronous serial line. Idles high.
- `ready`, input, 1: downstream accepts `data_out`.
- `data_out`, output, DATA_BITS: last received byte.
- `valid`, output, 1: `data_out` holds an unconsumed byte.
- `frame_err`, output, 1: stop bit of the byte in `data_out` was sampled 0.
- `overrun`, output, 1: one-cycle pulse when a frame completes while `valid` is still high.
- `parity_err`, output, 1: present only with `UART_RX_PARITY_EN`.

## Operation
- **Synchronizer:** `rxd` passes through 2 flops, both reset to 1. Everything below uses the synchronized signal `rxs`.
- **Tick generator:** counts `BAUD_DIV` clocks and emits a 1-cycle `tick`. It is held cleared in IDLE.
- **Oversample counter:** advances on each `tick`. It clears on every state change.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** when `rxs`=0, go to START.
- **START:** after `OVERSAMPLE/2` ticks (mid-bit), sample `rxs`.
  - Sample is 1: treat as a glitch and return to IDLE.
  - Sample is 0: go to DATA.
- **DATA:** every `OVERSAMPLE` ticks, sample `rxs` and shift it in at the MSB of the shift register, shifting right. After `DATA_BITS` samples, go to STOP (or to PARITY with the macro).
- **STOP:** after `OVERSAMPLE` ticks, sample `rxs` and go to IDLE immediately, at mid stop bit. This allows back-to-back frames.
- **Frame completion when `valid`=0:** load `data_out` from the shift register, set `frame_err` to the inverse of the stop sample, and set `valid`=1.
- **Frame completion when `valid`=1:** drop the new byte. `data_out`, `frame_err` and `parity_err` are unchanged, and `overrun` pulses for 1 cycle.
- **Handshake:** `valid` clears on the clock edge where `valid && ready`. If a completion lands on the same edge as a consume, the new byte loads, `valid` stays 1, and no overrun is flagged.
- **Reset:** `rst`=0 at any time, including mid-frame, returns the block to IDLE and clears both counters. Output reset values:
  - `data_out`=0
  - `valid`=0
  - `frame_err`=0
  - `overrun`=0
  - `parity_err`=0

## Timing
- Bit period is `BAUD_DIV*OVERSAMPLE` clocks; the defaults give 64.
- Synchronizer latency is 2 clocks from an `rxd` edge to `rxs`.
- Start sample falls `BAUD_DIV*OVERSAMPLE/2` clocks after the FSM enters START.
- Data bit k is sampled `BAUD_DIV*OVERSAMPLE*(k+1)` clocks after the start sample.
- `valid` rises 1 clock after the stop-sample tick.
- IDLE can detect the next start edge on the cycle after it is entered.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- **Defined:**
  - After DATA, a PARITY state samples one extra bit `OVERSAMPLE` ticks later, using even parity.
  - `parity_err` = XOR of the data bits and the parity bit. It is loaded with `data_out` and held like `frame_err`.
  - The frame is 1 bit longer.
- **Undefined:** no PARITY state and no `parity_err` port. The frame is 8N1 with the default `DATA_BITS`.

## Structure
- Package `uart_pkg` holds:
  - the FSM state typedef
  - default constants `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8
  - a parity function
- Sub-module `uart_tick_gen` holds the `BAUD_DIV` divider with enable and clear, producing `tick`. The transmitter reuses it.

## Test plan
All scenarios use the defaults: `BAUD_DIV`=4, `OVERSAMPLE`=16, 64 clocks per bit.
1. Send 0xA5 8N1 with `ready`=1 → `valid` is high for 1 cycle, `data_out`=0xA5, `frame_err`=0.
2. Drive `rxd` low for 20 clocks, then high → no `valid`, and the FSM is back in IDLE before clock 40.
3. Send 0x3C with the stop bit driven 0 → `valid`=1, `data_out`=0x3C, `frame_err`=1.
4. Hold `ready`=0 and send 0x11 then 0x22 back-to-back → `data_out` stays 0x11 and `overrun` pulses once at the second stop sample. Then set `ready`=1 → `valid` drops the next cycle.
5. Pull `rst` low after 4 data bits of 0xFF, then send 0x5A → outputs hold their reset values during reset, then `data_out`=0x5A is received cleanly.
6. With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err`=1. Send 0x07 with parity bit 1 → `parity_err`=0.
